enemy_bullet: RTL
=================

ENEMY_BULLET -- requirements
Module: enemy_bullet

Interface
REQ-001 Parameter COOLDOWN, default 64, IDLE cycles between a bullet ending and the next fire.
REQ-002 Parameter SCREEN_H, default 480, bottom despawn row.
REQ-003 Parameter HIT_R, default 8, half-size of the square player hitbox in pixels.
REQ-004 Parameter HP_INIT, default 3, player hit points after reset.
REQ-005 clk_22  input  1  game-logic clock; single clock domain.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 bossx, bossy  input  10 each  boss centre, fire origin.
REQ-008 reimux, reimuy  input  10 each  player centre.
REQ-009 enemy_bulletx, enemy_bullety  output reg  10 each  bullet position.
REQ-010 bullet_active  output reg  1  high while the bullet is in FLY.
REQ-011 reimu_hit  output reg  1  one-cycle pulse per player hit.
REQ-012 reimu_hp  output reg  3  remaining player hit points.

Function
REQ-013 FSM states: IDLE, FLY, HIT.
REQ-014 IDLE: cooldown counter increments each cycle; bullet held at (bossx, bossy+24); bullet_active=0.
REQ-015 IDLE->FLY when counter reaches COOLDOWN-1 and reimu_hp != 0; counter clears; position loads (bossx, bossy+24) on that same edge.
REQ-016 With reimu_hp==0 the block stays in IDLE permanently (counter frozen at COOLDOWN-1) until rst.
REQ-017 FLY step per cycle, chosen by current y: y<=120 add 1; 121..240 add 2; >240 add 4.
REQ-018 Step arithmetic is 11-bit: if y+step >= SCREEN_H, go to IDLE and reload spawn; no 10-bit wrap-around is ever visible on enemy_bullety.
REQ-019 Hit test in FLY on current position: |bx-reimux| < HIT_R and |by-reimuy| < HIT_R, using 11-bit signed differences.
REQ-020 Hit true: FLY->HIT; position frozen; reimu_hit=1 for exactly that HIT cycle; reimu_hp decrements, saturating at 0.
REQ-021 HIT->IDLE unconditionally after one cycle; counter starts from 0.
REQ-022 Hit and bottom crossing in the same cycle: the hit wins.
REQ-023 bullet_active=1 only in FLY; reimu_hit=1 only in HIT.

Reset
REQ-024 On rst: state IDLE, counter 0, enemy_bulletx=bossx, enemy_bullety=bossy+24, bullet_active=0, reimu_hit=0, reimu_hp=HP_INIT.
REQ-025 rst asserted mid-FLY or during HIT aborts the bullet; no hit pulse and no hp change occur on that edge.

Configuration
REQ-026 Macro ENEMY_BULLET_AIMED_EN.
- Defined: in FLY, x moves 1 px per cycle toward reimux (no move when equal), in addition to the y step.
- Undefined: x stays constant in FLY (straight drop).

Structure
REQ-027 Shared include file holds SCREEN_W=640, SCREEN_H=480, the 120/240 speed-band rows, and the state encodings.
REQ-028 Hit test is sub-module bullet_hitbox (purely combinational: two centres plus radius in, hit out); the team's boss/enemy collision logic reuses it.

Verification
REQ-029 rst, boss (320,50) -> bullet (320,74), hp=3, active=0; after 64 cycles FLY begins at y=74.
REQ-030 Player at (600,400), no aiming -> y steps +1 up to 120, then +2, then +4; despawns before 480; no hit; hp stays 3.
REQ-031 Player at (320,300) -> single reimu_hit pulse when |dy|<8; hp 3->2; IDLE next cycle.
REQ-032 Three hits, then a fourth bullet window -> hp reaches 0 and saturates; no further FLY occurs; rst restores hp=3.
REQ-033 rst pulsed at y=200 in FLY -> next cycle IDLE, y=bossy+24, no hit pulse.
REQ-034 ENEMY_BULLET_AIMED_EN defined, boss x=320, player x=330 -> x increments to 330 and then holds at 330.

Source files
------------

// File: rtl/enemy_bullet_pkg.sv
// Shared playfield constants, speed-band rows and FSM state encodings for the enemy bullet
// and any other block that reuses its hitbox or screen geometry.
package enemy_bullet_pkg;

    localparam int POS_W         = 10;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int BAND_SLOW_ROW = 120;
    localparam int BAND_MID_ROW  = 240;
    localparam int SPAWN_DY      = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_HIT  = 2'd2
    } state_e;

    // Bullets accelerate as they fall: slow near the boss, fastest in the bottom band.
    function automatic logic [2:0] fly_step(input logic [POS_W-1:0] y);
        if (y <= 10'(BAND_SLOW_ROW)) begin
            return 3'd1;
        end else if (y <= 10'(BAND_MID_ROW)) begin
            return 3'd2;
        end else begin
            return 3'd4;
        end
    endfunction

endpackage

// File: rtl/bullet_hitbox.sv
// Combinational square-hitbox test: hit when both axis distances between two centres
// are strictly below the radius. Shared with the boss/enemy collision logic.
module bullet_hitbox
    import enemy_bullet_pkg::*;
(
    input  logic [POS_W-1:0] ax_i,
    input  logic [POS_W-1:0] ay_i,
    input  logic [POS_W-1:0] bx_i,
    input  logic [POS_W-1:0] by_i,
    input  logic [POS_W-1:0] radius_i,
    output logic             hit_o
);

    logic signed [POS_W:0] dx;
    logic signed [POS_W:0] dy;
    logic        [POS_W:0] adx;
    logic        [POS_W:0] ady;

    // One extra bit keeps the difference of two unsigned 10-bit coordinates exact.
    always_comb begin
        dx    = $signed({1'b0, ax_i}) - $signed({1'b0, bx_i});
        dy    = $signed({1'b0, ay_i}) - $signed({1'b0, by_i});
        adx   = dx[POS_W] ? $unsigned(-dx) : $unsigned(dx);
        ady   = dy[POS_W] ? $unsigned(-dy) : $unsigned(dy);
        hit_o = (adx < {1'b0, radius_i}) && (ady < {1'b0, radius_i});
    end

endmodule

// File: rtl/enemy_bullet.sv
// Boss bullet: cooldown in IDLE, banded-speed fall in FLY, one-cycle HIT that costs the
// player a hit point. Define ENEMY_BULLET_AIMED_EN to make the bullet track the player in x.
module enemy_bullet #(
    parameter int COOLDOWN = 64,
    parameter int SCREEN_H = enemy_bullet_pkg::SCREEN_H,
    parameter int HIT_R    = 8,
    parameter int HP_INIT  = 3
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic [9:0] reimux,
    input  logic [9:0] reimuy,
    output logic [9:0] enemy_bulletx,
    output logic [9:0] enemy_bullety,
    output logic       bullet_active,
    output logic       reimu_hit,
    output logic [2:0] reimu_hp
);

    import enemy_bullet_pkg::*;

    localparam int               CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN - 1);
    localparam logic [10:0]      BOTTOM   = 11'(SCREEN_H);
    localparam logic [9:0]       RADIUS   = 10'(HIT_R);
    localparam logic [2:0]       HP_RESET = 3'(HP_INIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             active_q, active_d;
    logic             hit_q, hit_d;
    logic [2:0]       hp_q, hp_d;

    logic [9:0]  spawn_x;
    logic [9:0]  spawn_y;
    logic [10:0] y_next;
    logic [9:0]  x_aim;
    logic        hit_now;

    assign spawn_x = bossx;
    assign spawn_y = bossy + 10'(SPAWN_DY);
    // 11-bit sum so a step past the bottom row is detected instead of wrapping.
    assign y_next  = {1'b0, y_q} + {8'd0, fly_step(y_q)};

    bullet_hitbox u_hitbox (
        .ax_i     (x_q),
        .ay_i     (y_q),
        .bx_i     (reimux),
        .by_i     (reimuy),
        .radius_i (RADIUS),
        .hit_o    (hit_now)
    );

`ifdef ENEMY_BULLET_AIMED_EN
    always_comb begin
        if (x_q < reimux) begin
            x_aim = x_q + 10'd1;
        end else if (x_q > reimux) begin
            x_aim = x_q - 10'd1;
        end else begin
            x_aim = x_q;
        end
    end
`else
    assign x_aim = x_q;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        hp_d    = hp_q;

        unique case (state_q)
            ST_IDLE: begin
                x_d = spawn_x;
                y_d = spawn_y;
                if (cnt_q == CNT_LAST) begin
                    // With no hit points left the counter parks here until reset.
                    if (hp_q != 3'd0) begin
                        state_d = ST_FLY;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_FLY: begin
                if (hit_now) begin
                    state_d = ST_HIT;
                    hp_d    = (hp_q == 3'd0) ? 3'd0 : hp_q - 3'd1;
                end else if (y_next >= BOTTOM) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    x_d     = spawn_x;
                    y_d     = spawn_y;
                end else begin
                    x_d = x_aim;
                    y_d = y_next[9:0];
                end
            end

            ST_HIT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                x_d     = spawn_x;
                y_d     = spawn_y;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        active_d = (state_d == ST_FLY);
        hit_d    = (state_d == ST_HIT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_22) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            x_q      <= spawn_x;
            y_q      <= spawn_y;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            hp_q     <= HP_RESET;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            hp_q     <= hp_d;
        end
    end

    assign enemy_bulletx = x_q;
    assign enemy_bullety = y_q;
    assign bullet_active = active_q;
    assign reimu_hit     = hit_q;
    assign reimu_hp      = hp_q;

endmodule
